handshake_fifo: RTL and testbench
=================================

Name: handshake_fifo

Overview:
- Single-clock, parametrised successor to the four-phase handshake block.
- Accepts words from a req/ack producer in either four-phase (return-to-zero) or two-phase (toggle) mode.
- Optional synchroniser on the producer request; words are buffered in a DEPTH-entry FIFO.
- Words are presented to a streaming valid/ready consumer. Sits between slow request-driven sources and pipelined datapath logic.

Parameters:
N, 8, data width in bits (≥1)
DEPTH, 4, FIFO entries; power of 2, ≥2
MODE, 0, producer protocol: 0 = four-phase, 1 = two-phase toggle
SYNC_STAGES, 0, flops on reqIn before use: 0 = reqIn already synchronous to clk, 2 or 3 = synchroniser inserted

Ports:
clk  input  1  sole clock, all logic on rising edge
reset_n  input  1  synchronous, active-low reset
reqIn  input  1  producer request (level in MODE 0, toggle in MODE 1)
dataIn  input  N  producer data; stable from req change until ack response
ackIn  output  1  acknowledge to producer
validOut  output  1  consumer data valid
readyIn  input  1  consumer ready
dataOut  output  N  head-of-FIFO word; 0 when empty
count  output  $clog2(DEPTH+1)  words held
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset is synchronous: reset_n=0 sampled at an edge clears state. After that edge:
  - ackIn=0, validOut=0, dataOut=0, count=0, full=0, empty=1.
  - Read/write pointers and synchroniser flops are cleared.
  - Memory contents are not cleared.
- reqS = reqIn delayed by SYNC_STAGES flops (reqS = reqIn when SYNC_STAGES=0).
- Push condition:
  - MODE 0: reqS=1 && ackIn=0 && !full.
  - MODE 1: reqS != ackIn && !full.
- On a push edge:
  - mem[wrPtr] <= dataIn; wrPtr increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - MODE 0: ackIn <= 1. MODE 1: ackIn <= reqS.
- MODE 0 release: ackIn=1 && reqS=0 -> ackIn <= 0 next edge. Exactly one word per full req/ack cycle; holding reqIn=1 never causes a second capture.
- MODE 1: a stable reqIn causes no captures. One capture per reqIn toggle.
- Full: push is gated on the registered full flag. ackIn stays in its current phase and the producer stalls until an entry frees; capture then occurs on the first edge where full=0.
- Consumer side is show-ahead:
  - validOut = !empty; dataOut = mem[rdPtr] when !empty, else 0.
  - Pop on an edge where validOut && readyIn; rdPtr increments modulo DEPTH.
- Latency: a word captured at edge k gives validOut=1 after edge k. From a reqIn change to the ackIn change is SYNC_STAGES+1 edges when not full.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full with pop in the same cycle: pop only, since push uses the pre-edge full. Push occurs next edge.
- Empty: no pop possible. Push then pop earliest on the following edge.
- count, full and empty are registered and consistent with the pointers every cycle.
- Reset mid-operation:
  - The in-flight handshake and all buffered words are discarded.
  - MODE 0: a producer still holding reqIn=1 is treated as a new request.
  - MODE 1: a reqIn=1 after reset is treated as a pending toggle.
  - Producers must be reset together with this block.

Test Plan:
1. Reset: reset_n=0 for 3 edges with reqIn=1, readyIn=1 -> ackIn=0, validOut=0, dataOut=0x00, count=0, empty=1, full=0 after the first reset edge.
2. MODE 0, SYNC_STAGES=0, readyIn=0: set dataIn=0xAA, raise reqIn before edge k.
   - After edge k: ackIn=1, validOut=1, dataOut=0xAA, count=1.
   - Hold reqIn=1 for 5 more edges -> count stays 1.
   - Drop reqIn -> ackIn=0 after the next edge.
3. Fill/overflow, DEPTH=4, readyIn=0: four handshakes with 0x11, 0x22, 0x33, 0x44 -> count=4, full=1.
   - Fifth request 0x55 -> ackIn stays 0 for 10 edges, count=4.
   - Pulse readyIn=1 for 1 edge -> pops 0x11, full=0.
   - Next edge: ackIn=1, count=4.
4. Drain/wrap: readyIn=1 continuously after scenario 3 -> dataOut 0x22, 0x33, 0x44, 0x55 on consecutive cycles, then validOut=0, empty=1, dataOut=0x00. Pointers have wrapped with no data loss.
5. MODE 1, SYNC_STAGES=0: toggle reqIn three times with dataIn 0x01, 0x02, 0x03, spaced 4 edges apart.
   - Result: count=3, and ackIn equals reqIn one edge after each toggle.
   - Holding reqIn stable for 10 edges produces no further captures.
   - A simultaneous push/pop with readyIn=1 keeps count steady.
6. SYNC_STAGES=2, MODE 0: raise reqIn just after edge j -> ackIn=1 after edge j+3.
   - Assert reset_n=0 at edge j+5 while reqIn=1 and count=1 -> count=0, ackIn=0.
   - After release, the still-high reqIn is recaptured as a new word.

Source files
------------

// File: rtl/handshake_fifo.sv
`default_nettype none
// ============================================================================
// Module   : handshake_fifo
// Purpose  : Bridges a req/ack producer (four-phase or two-phase toggle) to a
//            streaming valid/ready consumer through a DEPTH-entry FIFO.
//            An optional synchroniser conditions the producer request.
// Ports    : clk      - sole clock, rising edge
//            reset_n  - synchronous active-low reset
//            reqIn    - producer request (level in MODE 0, toggle in MODE 1)
//            dataIn   - producer data, stable from req change until ack
//            ackIn    - acknowledge back to the producer
//            validOut - consumer data valid (FIFO not empty)
//            readyIn  - consumer ready
//            dataOut  - head-of-FIFO word, 0 when empty (show-ahead)
//            count    - number of words held
//            full     - count == DEPTH
//            empty    - count == 0
// Revision : 1.0 - initial release
// ============================================================================
module handshake_fifo #(
  parameter int N           = 8,
  parameter int DEPTH       = 4,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       reqIn,
  input  logic [N-1:0]               dataIn,
  output logic                       ackIn,
  output logic                       validOut,
  input  logic                       readyIn,
  output logic [N-1:0]               dataOut,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] c_full_count = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);

  logic             req_s;
  logic             push;
  logic             pop;

  logic             ack_q,    ack_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;

  logic [N-1:0]     mem [DEPTH];

  // --------------------------------------------------------------------------
  // Request conditioning: either used directly or passed through a flop chain
  // --------------------------------------------------------------------------
  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign req_s = reqIn;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = reqIn;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Producer handshake. Push is gated by the registered full flag, so a
  // producer facing a full FIFO simply sees its ack held in the old phase.
  // --------------------------------------------------------------------------
  generate
    if (MODE == 0) begin : g_four_phase
      // ack low + req high = new word; ack returns to zero once req drops,
      // so a held request can never be captured twice.
      assign push = req_s && !ack_q && !full_q;

      always_comb begin
        ack_d = ack_q;
        if (push) begin
          ack_d = 1'b1;
        end else if (ack_q && !req_s) begin
          ack_d = 1'b0;
        end
      end
    end else begin : g_two_phase
      // Any phase difference between req and ack is one outstanding word;
      // copying req into ack closes it.
      assign push = (req_s != ack_q) && !full_q;

      always_comb begin
        ack_d = ack_q;
        if (push) begin
          ack_d = req_s;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FIFO bookkeeping. DEPTH is a power of two, so pointer overflow is the
  // modulo-DEPTH wrap.
  // --------------------------------------------------------------------------
  assign pop = !empty_q && readyIn;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_one;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end

    if (push && !pop) begin
      count_d = count_q + c_cnt_one;
    end else if (!push && pop) begin
      count_d = count_q - c_cnt_one;
    end

    full_d  = (count_d == c_full_count);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is deliberately left unreset; the empty flag masks stale words.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem[wr_ptr_q] <= dataIn;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ackIn    = ack_q;
  assign validOut = !empty_q;
  assign dataOut  = empty_q ? '0 : mem[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_handshake_fifo
// Purpose  : Directed self-checking bench for handshake_fifo. Three instances:
//            u_a four-phase/no sync, u_b two-phase/no sync,
//            u_c four-phase/two-stage synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_handshake_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A: MODE 0, SYNC_STAGES 0 ----------------------
  logic       rst_a, req_a, ready_a, ack_a, valid_a, full_a, empty_a;
  logic [7:0] din_a, dout_a;
  logic [2:0] cnt_a;

  handshake_fifo #(.N(8), .DEPTH(4), .MODE(0), .SYNC_STAGES(0)) u_a (
    .clk(clk), .reset_n(rst_a), .reqIn(req_a), .dataIn(din_a), .ackIn(ack_a),
    .validOut(valid_a), .readyIn(ready_a), .dataOut(dout_a), .count(cnt_a),
    .full(full_a), .empty(empty_a)
  );

  // ---------------- instance B: MODE 1, SYNC_STAGES 0 ----------------------
  logic       rst_b, req_b, ready_b, ack_b, valid_b, full_b, empty_b;
  logic [7:0] din_b, dout_b;
  logic [2:0] cnt_b;

  handshake_fifo #(.N(8), .DEPTH(4), .MODE(1), .SYNC_STAGES(0)) u_b (
    .clk(clk), .reset_n(rst_b), .reqIn(req_b), .dataIn(din_b), .ackIn(ack_b),
    .validOut(valid_b), .readyIn(ready_b), .dataOut(dout_b), .count(cnt_b),
    .full(full_b), .empty(empty_b)
  );

  // ---------------- instance C: MODE 0, SYNC_STAGES 2 ----------------------
  logic       rst_c, req_c, ready_c, ack_c, valid_c, full_c, empty_c;
  logic [7:0] din_c, dout_c;
  logic [2:0] cnt_c;

  handshake_fifo #(.N(8), .DEPTH(4), .MODE(0), .SYNC_STAGES(2)) u_c (
    .clk(clk), .reset_n(rst_c), .reqIn(req_c), .dataIn(din_c), .ackIn(ack_c),
    .validOut(valid_c), .readyIn(ready_c), .dataOut(dout_c), .count(cnt_c),
    .full(full_c), .empty(empty_c)
  );

  // Advance one rising edge and settle 1 ns past it for sampling/driving.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete four-phase handshake on instance A (no synchroniser).
  task automatic hs_a(input logic [7:0] v);
    din_a = v;
    req_a = 1'b1;
    tick();
    check("hs_a_ack_high", 32'(ack_a), 32'd1);
    req_a = 1'b0;
    tick();
    check("hs_a_ack_low", 32'(ack_a), 32'd0);
  endtask

  initial begin
    // ------------------------------------------------------------ reset
    rst_a = 1'b0; req_a = 1'b1; ready_a = 1'b1; din_a = 8'h00;
    rst_b = 1'b0; req_b = 1'b0; ready_b = 1'b1; din_b = 8'h00;
    rst_c = 1'b0; req_c = 1'b0; ready_c = 1'b1; din_c = 8'h00;
    tick();
    check("rst_ack",   32'(ack_a),   32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_dout",  32'(dout_a),  32'h00);
    check("rst_count", 32'(cnt_a),   32'd0);
    check("rst_empty", 32'(empty_a), 32'd1);
    check("rst_full",  32'(full_a),  32'd0);
    check("rst_b_empty", 32'(empty_b), 32'd1);
    check("rst_c_count", 32'(cnt_c),   32'd0);
    tick(2);
    check("rst_hold_count", 32'(cnt_a), 32'd0);
    req_a = 1'b0; ready_a = 1'b0; ready_b = 1'b0; ready_c = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick();
    check("idle_count", 32'(cnt_a), 32'd0);

    // ------------------------------------------------ four-phase capture
    din_a = 8'hAA; req_a = 1'b1;
    tick();
    check("cap_ack",   32'(ack_a),   32'd1);
    check("cap_valid", 32'(valid_a), 32'd1);
    check("cap_dout",  32'(dout_a),  32'hAA);
    check("cap_count", 32'(cnt_a),   32'd1);
    tick(5);
    check("hold_count", 32'(cnt_a), 32'd1);
    check("hold_ack",   32'(ack_a), 32'd1);
    req_a = 1'b0;
    tick();
    check("release_ack", 32'(ack_a), 32'd0);
    check("release_count", 32'(cnt_a), 32'd1);
    // drain the single word
    ready_a = 1'b1;
    tick();
    check("pop_aa_empty", 32'(empty_a), 32'd1);
    check("pop_aa_dout",  32'(dout_a),  32'h00);
    ready_a = 1'b0;

    // ------------------------------------------------ fill / overflow
    hs_a(8'h11); hs_a(8'h22); hs_a(8'h33); hs_a(8'h44);
    check("fill_count", 32'(cnt_a),  32'd4);
    check("fill_full",  32'(full_a), 32'd1);
    check("fill_head",  32'(dout_a), 32'h11);
    din_a = 8'h55; req_a = 1'b1;
    tick(10);
    check("stall_ack",   32'(ack_a), 32'd0);
    check("stall_count", 32'(cnt_a), 32'd4);
    ready_a = 1'b1;
    tick();
    check("free_full",  32'(full_a), 32'd0);
    check("free_count", 32'(cnt_a),  32'd3);
    check("free_ack",   32'(ack_a),  32'd0);
    check("free_head",  32'(dout_a), 32'h22);
    ready_a = 1'b0;
    tick();
    check("late_push_ack",   32'(ack_a),  32'd1);
    check("late_push_count", 32'(cnt_a),  32'd4);
    check("late_push_full",  32'(full_a), 32'd1);

    // ------------------------------------------------ drain across wrap
    req_a = 1'b0; ready_a = 1'b1;
    check("drain_0", 32'(dout_a), 32'h22);
    tick();
    check("drain_1", 32'(dout_a), 32'h33);
    tick();
    check("drain_2", 32'(dout_a), 32'h44);
    tick();
    check("drain_3", 32'(dout_a), 32'h55);
    tick();
    check("drain_valid", 32'(valid_a), 32'd0);
    check("drain_empty", 32'(empty_a), 32'd1);
    check("drain_dout",  32'(dout_a),  32'h00);
    check("drain_ack",   32'(ack_a),   32'd0);

    // ------------------------------------------------ two-phase toggles
    din_b = 8'h01; req_b = 1'b1;
    tick();
    check("tog1_ack",   32'(ack_b), 32'(req_b));
    check("tog1_count", 32'(cnt_b), 32'd1);
    tick(3);
    din_b = 8'h02; req_b = 1'b0;
    tick();
    check("tog2_ack",   32'(ack_b), 32'(req_b));
    check("tog2_count", 32'(cnt_b), 32'd2);
    tick(3);
    din_b = 8'h03; req_b = 1'b1;
    tick();
    check("tog3_ack",   32'(ack_b), 32'(req_b));
    check("tog3_count", 32'(cnt_b), 32'd3);
    tick(10);
    check("stable_count", 32'(cnt_b),  32'd3);
    check("stable_head",  32'(dout_b), 32'h01);
    din_b = 8'h04; req_b = 1'b0; ready_b = 1'b1;
    tick();
    check("pushpop_count", 32'(cnt_b),  32'd3);
    check("pushpop_ack",   32'(ack_b),  32'd0);
    check("pushpop_head",  32'(dout_b), 32'h02);
    ready_b = 1'b0;
    tick();
    check("pushpop_after", 32'(cnt_b), 32'd3);

    // ------------------------------------------------ synchronised request
    // we are just after edge j
    din_c = 8'hC3; req_c = 1'b1;
    tick(2);                      // edge j+2
    check("sync_ack_early", 32'(ack_c), 32'd0);
    tick();                       // edge j+3
    check("sync_ack",   32'(ack_c),  32'd1);
    check("sync_count", 32'(cnt_c),  32'd1);
    check("sync_dout",  32'(dout_c), 32'hC3);
    tick();                       // edge j+4
    check("sync_pre_rst_count", 32'(cnt_c), 32'd1);
    rst_c = 1'b0;
    tick();                       // edge j+5, reset sampled
    check("midrst_count", 32'(cnt_c),   32'd0);
    check("midrst_ack",   32'(ack_c),   32'd0);
    check("midrst_valid", 32'(valid_c), 32'd0);
    rst_c = 1'b1; din_c = 8'hC4;
    tick(2);                      // sync chain refilling
    check("recap_wait", 32'(cnt_c), 32'd0);
    tick();
    check("recap_ack",   32'(ack_c),  32'd1);
    check("recap_count", 32'(cnt_c),  32'd1);
    check("recap_dout",  32'(dout_c), 32'hC4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
